// File: rtl/m_mem_access_unit_if.sv
// Data bus between the M-stage load/store unit (master) and memory (slave).
// One request is held until it is completed by bus_ack or bus_err.
interface m_mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [NB-1:0]     bus_byteen;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic              bus_err;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
    input  bus_ack, bus_err, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
    output bus_ack, bus_err, bus_rdata
  );
endinterface

// File: rtl/m_mem_access_unit.sv
// M-stage load/store unit: turns a decoded load/store into one bus
// transaction, stalls the pipeline while it is in flight and reports
// alignment and bus faults to CP0.
//
// state | meaning
// IDLE  | waiting for an access; misaligned accesses go straight to DONE
// REQ   | bus request held until ack, err or timeout
// DONE  | one-cycle result/exception presentation, pipeline released
module m_mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid,
  input  logic              m_load,
  input  logic              m_store,
  input  logic [1:0]        m_size,
  input  logic              m_signed,
  input  logic              m_flush,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic              m_stall,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_rdata_valid,
  output logic [1:0]        m_exc,
  m_mem_access_unit_if.master bus
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nxt;

  logic              req_q, we_q, load_q, signed_q, killed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NB-1:0]     byteen_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [1:0]        size_q, exc_q;
  logic [LB-1:0]     lane_q;
  logic [7:0]        cnt_q;

  logic              access, misaligned, timed_out, kill_done;
  logic [LB-1:0]     lane, src;
  logic [3:0]        bytes_m1, ld_bytes_m1;
  logic [NB-1:0]     size_mask, byteen_nxt;
  logic [DATA_W-1:0] wdata_rep, shifted, ld_mask, load_ext;
  logic              sbit;

  assign access     = m_valid & (m_load | m_store) & ~m_flush;
  assign lane       = m_addr[LB-1:0];
  assign misaligned = ((m_size == 2'd1) & m_addr[0])
                    | ((m_size == 2'd2) & (m_addr[1:0] != 2'b00))
                    | ((m_size == 2'd3) & ((m_addr[2:0] != 3'b000) | (DATA_W == 32)));
  assign timed_out  = (cnt_q == 8'(TIMEOUT - 1));

  // Request decode: byte enables and store data replicated across lanes.
  always_comb begin
    bytes_m1  = (4'd1 << m_size) - 4'd1;
    size_mask = '0;
    wdata_rep = '0;
    src       = '0;
    for (int i = 0; i < NB; i++) begin
      size_mask[i] = (i <= int'(bytes_m1));
      src = LB'(i) & bytes_m1[LB-1:0];
      wdata_rep[8*i +: 8] = m_wdata[{src, 3'b000} +: 8];
    end
    byteen_nxt = size_mask << lane;
  end

  // Load alignment: shift the addressed lane down, then sign/zero extend.
  always_comb begin
    ld_bytes_m1 = (4'd1 << size_q) - 4'd1;
    shifted     = bus.bus_rdata >> {lane_q, 3'b000};
    ld_mask     = '0;
    for (int i = 0; i < NB; i++)
      ld_mask[8*i +: 8] = (i <= int'(ld_bytes_m1)) ? 8'hFF : 8'h00;
    case (size_q)
      2'd0:    sbit = shifted[7];
      2'd1:    sbit = shifted[15];
      2'd2:    sbit = shifted[31];
      default: sbit = 1'b0;
    endcase
    load_ext = (shifted & ld_mask) | ({DATA_W{signed_q & sbit}} & ~ld_mask);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and stall decode.
  always_comb begin
    state_nxt = state;
    m_stall   = 1'b0;
    case (state)
      IDLE: begin
        m_stall = access;
        if (access) state_nxt = misaligned ? DONE : REQ;
      end
      REQ: begin
        m_stall = 1'b1;
        if (bus.bus_ack | bus.bus_err | timed_out) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, bus hold, timeout counting and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      byteen_q <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      lane_q   <= '0;
      load_q   <= 1'b0;
      exc_q    <= '0;
      killed_q <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          killed_q <= 1'b0;
          cnt_q    <= '0;
          if (access) begin
            load_q <= m_load;
            if (misaligned) begin
              exc_q <= m_load ? 2'd1 : 2'd2;
            end else begin
              exc_q    <= 2'd0;
              req_q    <= 1'b1;
              we_q     <= m_store & ~m_load;
              addr_q   <= {m_addr[ADDR_W-1:LB], LB'(0)};
              byteen_q <= byteen_nxt;
              wdata_q  <= wdata_rep;
              size_q   <= m_size;
              signed_q <= m_signed;
              lane_q   <= lane;
            end
          end
        end
        REQ: begin
          if (m_flush) killed_q <= 1'b1;
          if (bus.bus_ack) begin
            req_q   <= 1'b0;
            rdata_q <= load_ext;
            cnt_q   <= '0;
          end else if (bus.bus_err | timed_out) begin
            req_q <= 1'b0;
            exc_q <= 2'd3;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: killed_q <= 1'b0;
      endcase
    end
  end

  // A flush seen during DONE discards the result just like an earlier one.
  assign kill_done     = killed_q | m_flush;
  assign m_rdata_valid = (state == DONE) & load_q & ~kill_done & (exc_q == 2'd0);
  assign m_exc         = ((state == DONE) & ~kill_done) ? exc_q : 2'd0;
  assign m_rdata       = rdata_q;

  assign bus.bus_req    = req_q;
  assign bus.bus_we     = we_q;
  assign bus.bus_addr   = addr_q;
  assign bus.bus_byteen = byteen_q;
  assign bus.bus_wdata  = wdata_q;

endmodule

// File: tb/tb_m_mem_access_unit.sv
// Bench for m_mem_access_unit (DATA_W=32, TIMEOUT=4): each access pushes its
// expected outcome to a scoreboard that is popped when the unit reaches DONE.
module tb_m_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m_valid = 1'b0, m_load = 1'b0, m_store = 1'b0;
  logic [1:0]  m_size = 2'd0;
  logic        m_signed = 1'b0, m_flush = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic        m_stall, m_rdata_valid;
  logic [31:0] m_rdata;
  logic [1:0]  m_exc;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0]  exc;
    logic        valid;
    logic [31:0] rdata;
    int          stalls;
    int          reqs;
  } exp_t;
  exp_t sb[$];

  m_mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) bus_if ();

  m_mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_load(m_load), .m_store(m_store), .m_size(m_size),
    .m_signed(m_signed), .m_flush(m_flush), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_stall(m_stall), .m_rdata(m_rdata), .m_rdata_valid(m_rdata_valid),
    .m_exc(m_exc), .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string name, input bit ld, input bit st, input logic [1:0] sz,
                     input bit sg, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] brdata, input int ack_at, input int err_at,
                     input int flush_at, input logic [1:0] e_exc, input bit e_valid,
                     input logic [31:0] e_rdata, input int e_stalls, input int e_reqs,
                     input logic [31:0] e_baddr, input logic [3:0] e_be,
                     input logic [31:0] e_bwdata, input bit e_we);
    exp_t e;
    int stalls = 0;
    int reqs = 0;
    bit done = 1'b0;
    e.exc = e_exc; e.valid = e_valid; e.rdata = e_rdata; e.stalls = e_stalls; e.reqs = e_reqs;
    sb.push_back(e);
    @(negedge clk);
    m_valid = 1'b1; m_load = ld; m_store = st; m_size = sz; m_signed = sg;
    m_addr = addr; m_wdata = wdata; bus_if.bus_rdata = brdata;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (m_stall) begin
        stalls++;
        if (bus_if.bus_req) begin
          reqs++;
          if (reqs == 1) begin
            chk({name, "_baddr"}, 64'(bus_if.bus_addr), 64'(e_baddr));
            chk({name, "_be"}, 64'(bus_if.bus_byteen), 64'(e_be));
            chk({name, "_bwdata"}, 64'(bus_if.bus_wdata), 64'(e_bwdata));
            chk({name, "_we"}, 64'(bus_if.bus_we), 64'(e_we));
          end
        end
        bus_if.bus_ack = bus_if.bus_req && (reqs == ack_at);
        bus_if.bus_err = bus_if.bus_req && (reqs == err_at);
        m_flush        = bus_if.bus_req && (reqs == flush_at);
        @(negedge clk);
      end else begin
        done = 1'b1;
        e = sb.pop_front();
        chk({name, "_exc"}, 64'(m_exc), 64'(e.exc));
        chk({name, "_valid"}, 64'(m_rdata_valid), 64'(e.valid));
        if (e.valid) chk({name, "_rdata"}, 64'(m_rdata), 64'(e.rdata));
        chk({name, "_stalls"}, 64'(stalls), 64'(e.stalls));
        chk({name, "_reqs"}, 64'(reqs), 64'(e.reqs));
      end
    end
    if (!done) begin
      chk({name, "_done_reached"}, 64'(0), 64'(1));
      void'(sb.pop_front());
    end
    m_valid = 1'b0; m_flush = 1'b0; bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0;
    @(negedge clk);
    #1 chk({name, "_strobe_off"}, 64'(m_rdata_valid), 64'(0));
  endtask

  initial begin
    bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0; bus_if.bus_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_stall", 64'(m_stall), 64'(0));
    chk("rst_req", 64'(bus_if.bus_req), 64'(0));
    chk("rst_valid", 64'(m_rdata_valid), 64'(0));
    chk("rst_exc", 64'(m_exc), 64'(0));
    chk("rst_be", 64'(bus_if.bus_byteen), 64'(0));
    reset = 1'b1;

    //   name   ld st sz sg addr        wdata         bus_rdata     ack err fl exc v rdata         st rq baddr       be       bwdata        we
    run("lw",   1, 0, 2, 0, 32'h100, 32'hDEADBEEF, 32'h800000F0, 1, 0, 0, 0, 1, 32'h800000F0, 2, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 0);
    run("lb",   1, 0, 0, 1, 32'h103, 32'h11223344, 32'h8A000000, 1, 0, 0, 0, 1, 32'hFFFFFF8A, 2, 1, 32'h100, 4'b1000, 32'h44444444, 0);
    run("lbu",  1, 0, 0, 0, 32'h103, 32'h11223344, 32'h8A000000, 1, 0, 0, 0, 1, 32'h0000008A, 2, 1, 32'h100, 4'b1000, 32'h44444444, 0);
    run("lh",   1, 0, 1, 1, 32'h102, 32'h00000000, 32'h80017FFF, 2, 0, 0, 0, 1, 32'hFFFF8001, 3, 2, 32'h100, 4'b1100, 32'h00000000, 0);
    run("sh",   0, 1, 1, 0, 32'h202, 32'h1234ABCD, 32'h00000000, 1, 0, 0, 0, 0, 32'h0,        2, 1, 32'h200, 4'b1100, 32'hABCDABCD, 1);
    run("sb",   0, 1, 0, 0, 32'h301, 32'h00000055, 32'h00000000, 1, 0, 0, 0, 0, 32'h0,        2, 1, 32'h300, 4'b0010, 32'h55555555, 1);
    run("adel", 1, 0, 2, 0, 32'h101, 32'h0,        32'h0,        1, 0, 0, 1, 0, 32'h0,        1, 0, 32'h0,   4'b0000, 32'h0,        0);
    run("ades", 0, 1, 2, 0, 32'h102, 32'h0,        32'h0,        1, 0, 0, 2, 0, 32'h0,        1, 0, 32'h0,   4'b0000, 32'h0,        0);
    run("ld64", 1, 0, 3, 0, 32'h100, 32'h0,        32'h0,        1, 0, 0, 1, 0, 32'h0,        1, 0, 32'h0,   4'b0000, 32'h0,        0);
    run("sd64", 0, 1, 3, 0, 32'h108, 32'h0,        32'h0,        1, 0, 0, 2, 0, 32'h0,        1, 0, 32'h0,   4'b0000, 32'h0,        0);
    run("tmo",  1, 0, 2, 0, 32'h104, 32'h0,        32'h0,        0, 0, 0, 3, 0, 32'h0,        5, 4, 32'h104, 4'b1111, 32'h0,        0);
    run("berr", 1, 0, 2, 0, 32'h104, 32'h0,        32'h0,        0, 2, 0, 3, 0, 32'h0,        3, 2, 32'h104, 4'b1111, 32'h0,        0);
    run("ackerr",1,0, 2, 0, 32'h108, 32'h0,        32'h12345678, 1, 1, 0, 0, 1, 32'h12345678, 2, 1, 32'h108, 4'b1111, 32'h0,        0);
    run("flush",1, 0, 2, 0, 32'h10C, 32'h0,        32'hCAFEF00D, 4, 0, 1, 0, 0, 32'h0,        5, 4, 32'h10C, 4'b1111, 32'h0,        0);

    // flush in IDLE: nothing starts
    @(negedge clk);
    m_valid = 1'b1; m_load = 1'b1; m_size = 2'd2; m_addr = 32'h100; m_flush = 1'b1;
    #1 chk("idle_flush_stall", 64'(m_stall), 64'(0));
    @(negedge clk);
    #1 chk("idle_flush_req", 64'(bus_if.bus_req), 64'(0));
    m_valid = 1'b0; m_flush = 1'b0;

    // reset mid-REQ drops bus_req asynchronously
    @(negedge clk);
    m_valid = 1'b1; m_load = 1'b1; m_size = 2'd2; m_addr = 32'h100;
    @(negedge clk);
    m_valid = 1'b0;
    #1 chk("midreq_req_up", 64'(bus_if.bus_req), 64'(1));
    reset = 1'b0;
    #1 chk("midreq_req_drop", 64'(bus_if.bus_req), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    run("recov",1, 0, 2, 0, 32'h110, 32'h0,        32'h00C0FFEE, 2, 0, 0, 0, 1, 32'h00C0FFEE, 3, 2, 32'h110, 4'b1111, 32'h0,        0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
